// File: rtl/core_bus_rarb.sv
// Read-channel arbiter/sequencer sharing one AXI-style read bus among refill/uncached requesters.
// Optional RARB_ROUND_ROBIN_EN selects round-robin arbitration; default build is fixed priority.
module core_bus_rarb #(
  parameter int unsigned REQ_CNT = 2,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQ_CNT-1:0]       req_valid_i,
  input  logic [REQ_CNT*32-1:0]    req_addr_i,
  input  logic [REQ_CNT*LEN_W-1:0] req_len_i,
  input  logic [REQ_CNT*2-1:0]     req_size_i,
  output logic [REQ_CNT-1:0]       req_ready_o,
  output logic [REQ_CNT-1:0]       resp_valid_o,
  output logic                     resp_last_o,
  output logic [31:0]              resp_data_o,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  output logic [31:0]              ar_addr_o,
  output logic [LEN_W-1:0]         ar_len_o,
  output logic [1:0]               ar_size_o,
  input  logic                     r_valid_i,
  input  logic                     r_last_i,
  input  logic [31:0]              r_data_i,
  output logic                     r_ready_o,
  output logic                     busy_o,
  output logic                     len_err_o
);

  localparam int unsigned GNT_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  typedef struct packed {
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
    logic [1:0]       size;
  } rd_req_t;

  state_e           state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  rd_req_t          req_q, req_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ar_valid_q, ar_valid_d;
  logic             busy_q, busy_d;
  logic [GNT_W-1:0] pick;
  logic [GNT_W-1:0] base;
  rd_req_t          sel_req;
  logic [REQ_CNT-1:0] gnt_oh;

`ifdef RARB_ROUND_ROBIN_EN
  logic [GNT_W-1:0] ptr_q, ptr_d;
`endif

  // (a + k) mod REQ_CNT, with a and k both below REQ_CNT
  function automatic logic [GNT_W-1:0] wrap_inc(input logic [GNT_W-1:0] a, input int unsigned k);
    logic [GNT_W:0] sum;
    sum = {1'b0, a} + (GNT_W+1)'(k);
    if (sum >= (GNT_W+1)'(REQ_CNT)) begin
      sum = sum - (GNT_W+1)'(REQ_CNT);
    end
    return sum[GNT_W-1:0];
  endfunction

  // First valid requester at or above base, wrapping
  function automatic logic [GNT_W-1:0] arb_pick(input logic [REQ_CNT-1:0] v, input logic [GNT_W-1:0] b);
    logic [GNT_W-1:0] cand;
    logic [GNT_W-1:0] res;
    logic             found;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      cand = wrap_inc(b, i);
      if (!found && v[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

`ifdef RARB_ROUND_ROBIN_EN
  assign base = ptr_q;
`else
  assign base = '0;
`endif

  assign pick = arb_pick(req_valid_i, base);

  // Mux the winning requester's fields with constant-index slices
  always_comb begin
    sel_req = '0;
    for (int c = 0; c < REQ_CNT; c++) begin
      if (GNT_W'(c) == pick) begin
        sel_req = {req_addr_i[32*c +: 32], req_len_i[LEN_W*c +: LEN_W], req_size_i[2*c +: 2]};
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int c = 0; c < REQ_CNT; c++) begin
      gnt_oh[c] = (GNT_W'(c) == grant_q);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      req_q      <= '0;
      cnt_q      <= '0;
      ar_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RARB_ROUND_ROBIN_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      ar_valid_q <= ar_valid_d;
      busy_q     <= busy_d;
`ifdef RARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
`ifdef RARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          state_d = S_ADDR;
          grant_d = pick;
          req_d   = sel_req;
        end
      end
      S_ADDR: begin
        if (ar_ready_i) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (r_valid_i) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (r_last_i) begin
            state_d = S_IDLE;
`ifdef RARB_ROUND_ROBIN_EN
            ptr_d   = wrap_inc(grant_q, 1);
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ar_valid_d = (state_d == S_ADDR);
    busy_d     = (state_d != S_IDLE);
  end

  // Combinational handshake and response routing
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    resp_last_o  = 1'b0;
    resp_data_o  = '0;
    r_ready_o    = 1'b0;
    len_err_o    = 1'b0;
    case (state_q)
      S_ADDR: begin
        if (ar_ready_i) begin
          req_ready_o = gnt_oh;
        end
      end
      S_DATA: begin
        r_ready_o    = 1'b1;
        resp_valid_o = r_valid_i ? gnt_oh : '0;
        resp_data_o  = r_data_i;
        resp_last_o  = r_valid_i && r_last_i;
        len_err_o    = r_valid_i && r_last_i && (cnt_q != req_q.len);
      end
      default: ;
    endcase
  end

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = req_q.addr;
  assign ar_len_o   = req_q.len;
  assign ar_size_o  = req_q.size;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_core_bus_rarb.sv
// Directed self-checking bench for core_bus_rarb (REQ_CNT=2, LEN_W=8).
module tb_core_bus_rarb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic [3:0]  req_size;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic        resp_last;
  logic [31:0] resp_data;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [1:0]  ar_size;
  logic        r_valid;
  logic        r_last;
  logic [31:0] r_data;
  logic        r_ready;
  logic        busy;
  logic        len_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ptr = 0;

  core_bus_rarb #(.REQ_CNT(2), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_size_i  (req_size),
    .req_ready_o (req_ready),
    .resp_valid_o(resp_valid),
    .resp_last_o (resp_last),
    .resp_data_o (resp_data),
    .ar_valid_o  (ar_valid),
    .ar_ready_i  (ar_ready),
    .ar_addr_o   (ar_addr),
    .ar_len_o    (ar_len),
    .ar_size_o   (ar_size),
    .r_valid_i   (r_valid),
    .r_last_i    (r_last),
    .r_data_i    (r_data),
    .r_ready_o   (r_ready),
    .busy_o      (busy),
    .len_err_o   (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 0) ? 2'b01 : 2'b10;
  endfunction

  // Winner when both requesters are valid in S_IDLE
  function automatic int both_winner();
`ifdef RARB_ROUND_ROBIN_EN
    return exp_ptr;
`else
    return 0;
`endif
  endfunction

  task automatic set_req(input int idx, input logic [31:0] a, input logic [7:0] l, input logic [1:0] s);
    req_valid[idx]       = 1'b1;
    req_addr[idx*32 +: 32] = a;
    req_len[idx*8 +: 8]    = l;
    req_size[idx*2 +: 2]   = s;
  endtask

  // Present request (or rely on one already present), check address phase, accept it
  task automatic issue(input int idx, input logic [31:0] a, input logic [7:0] l, input logic [1:0] s);
    set_req(idx, a, l, s);
    #1;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_ar_valid", 32'(ar_valid), 32'd0);
    tick;
    check_eq("ar_valid", 32'(ar_valid), 32'd1);
    check_eq("ar_addr", ar_addr, a);
    check_eq("ar_len", 32'(ar_len), 32'(l));
    check_eq("ar_size", 32'(ar_size), 32'(s));
    check_eq("addr_busy", 32'(busy), 32'd1);
    check_eq("no_ready_before_ar", 32'(req_ready), 32'd0);
    ar_ready = 1'b1;
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(onehot(idx)));
    tick;
    ar_ready       = 1'b0;
    req_valid[idx] = 1'b0;
    check_eq("data_ar_valid", 32'(ar_valid), 32'd0);
    check_eq("data_r_ready", 32'(r_ready), 32'd1);
  endtask

  task automatic beat(input int idx, input logic [31:0] d, input logic last, input logic err);
    r_valid = 1'b1;
    r_last  = last;
    r_data  = d;
    #1;
    check_eq("resp_valid", 32'(resp_valid), 32'(onehot(idx)));
    check_eq("resp_last", 32'(resp_last), 32'(last));
    check_eq("resp_data", resp_data, d);
    check_eq("len_err", 32'(len_err), 32'(err));
    tick;
    r_valid = 1'b0;
    r_last  = 1'b0;
    if (last) begin
      exp_ptr = (idx + 1) % 2;
      check_eq("done_busy", 32'(busy), 32'd0);
      check_eq("done_r_ready", 32'(r_ready), 32'd0);
    end
  endtask

  task automatic gap;
    #1;
    check_eq("gap_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("gap_resp_last", 32'(resp_last), 32'd0);
    tick;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_ar_valid"}, 32'(ar_valid), 32'd0);
    check_eq({pfx, "_ar_addr"}, ar_addr, 32'd0);
    check_eq({pfx, "_ar_len"}, 32'(ar_len), 32'd0);
    check_eq({pfx, "_ar_size"}, 32'(ar_size), 32'd0);
    check_eq({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({pfx, "_resp_last"}, 32'(resp_last), 32'd0);
    check_eq({pfx, "_resp_data"}, resp_data, 32'd0);
    check_eq({pfx, "_r_ready"}, 32'(r_ready), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_len_err"}, 32'(len_err), 32'd0);
  endtask

  initial begin
    int w;
    int l;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    req_size  = '0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_last    = 1'b0;
    r_data    = '0;
    tick;
    tick;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Single uncached dcache read
    issue(1, 32'h1FE0_0000, 8'd0, 2'd2);
    beat(1, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Both requesters valid together
    set_req(0, 32'h0000_1000, 8'd0, 2'd2);
    set_req(1, 32'h0000_2000, 8'd0, 2'd2);
    w = both_winner();
    l = 1 - w;
    issue(w, (w == 0) ? 32'h0000_1000 : 32'h0000_2000, 8'd0, 2'd2);
    beat(w, 32'h0000_00A1, 1'b1, 1'b0);
    issue(l, (l == 0) ? 32'h0000_1000 : 32'h0000_2000, 8'd0, 2'd2);
    beat(l, 32'h0000_00A2, 1'b1, 1'b0);

    // Refill burst with two idle cycles between beats
    issue(0, 32'h8000_0040, 8'd3, 2'd2);
    for (int b = 0; b < 4; b++) begin
      beat(0, 32'hC0DE_0000 + 32'(b), (b == 3), 1'b0);
      if (b != 3) begin
        gap;
        gap;
      end
    end

    // Both valid again, pointer now follows the refill grant
    set_req(0, 32'h0000_3000, 8'd0, 2'd1);
    set_req(1, 32'h0000_4000, 8'd0, 2'd0);
    w = both_winner();
    l = 1 - w;
    issue(w, (w == 0) ? 32'h0000_3000 : 32'h0000_4000, 8'd0, (w == 0) ? 2'd1 : 2'd0);
    beat(w, 32'h0000_00B1, 1'b1, 1'b0);
    issue(l, (l == 0) ? 32'h0000_3000 : 32'h0000_4000, 8'd0, (l == 0) ? 2'd1 : 2'd0);
    beat(l, 32'h0000_00B2, 1'b1, 1'b0);

    // Length mismatch: len 3, last on second beat
    issue(0, 32'h8000_0080, 8'd3, 2'd2);
    beat(0, 32'h1111_0000, 1'b0, 1'b0);
    beat(0, 32'h1111_0001, 1'b1, 1'b1);
    check_eq("len_err_after", 32'(len_err), 32'd0);

    // Address stall for five cycles
    set_req(1, 32'h1FE0_0010, 8'd0, 2'd0);
    tick;
    for (int c = 0; c < 5; c++) begin
      check_eq("stall_ar_valid", 32'(ar_valid), 32'd1);
      check_eq("stall_ar_addr", ar_addr, 32'h1FE0_0010);
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      tick;
    end
    ar_ready = 1'b1;
    #1;
    check_eq("stall_req_ready_go", 32'(req_ready), 32'b10);
    tick;
    ar_ready     = 1'b0;
    req_valid[1] = 1'b0;
    beat(1, 32'h0000_5A5A, 1'b1, 1'b0);

    // Reset during second beat of a four-beat burst
    issue(0, 32'h8000_00C0, 8'd3, 2'd2);
    beat(0, 32'h2222_0000, 1'b0, 1'b0);
    r_valid = 1'b1;
    r_data  = 32'h2222_0001;
    rst_n   = 1'b0;
    #1;
    check_all_zero("midrst");
    tick;
    tick;
    rst_n   = 1'b1;
    r_valid = 1'b0;
    exp_ptr = 0;
    issue(1, 32'h1FE0_0020, 8'd0, 2'd2);
    beat(1, 32'h3333_3333, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
